// File: rtl/ready_gen_if.sv
//------------------------------------------------------------------------------
// ready_gen_if
//
// Purpose : Groups the bus-cycle and handshake signals between the FSB side
//           (bus-cycle block, region decoder, refresh timer, I/O bridge) and
//           the wait-state / Ready generator.
//
// Signals :
//   BACT      - bus cycle active from FSB (level, high for the whole cycle)
//   RAMCS     - RAM region select, valid while BACT
//   ROMCS     - ROM region select, valid while BACT
//   IOCS      - I/O region select (selects are mutually exclusive)
//   RefReq    - refresh request pulse from refresh timer
//   IODone    - I/O bridge completion, FCLK-synchronous level
//   Ready     - to FSB; high allows DTACK
//   IOREQ     - I/O access request to bridge
//   RefActive - refresh in progress (RAS-only strobe enable)
//   RefAck    - one-cycle pulse after refresh completes
//   IOTimeout - one-cycle pulse on I/O timeout
//
// Modports:
//   master - the FSB / environment side (drives selects and requests)
//   slave  - the ready_gen side (drives Ready and the status outputs)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface ready_gen_if;
    logic BACT;
    logic RAMCS;
    logic ROMCS;
    logic IOCS;
    logic RefReq;
    logic IODone;
    logic Ready;
    logic IOREQ;
    logic RefActive;
    logic RefAck;
    logic IOTimeout;

    modport master (
        output BACT,
        output RAMCS,
        output ROMCS,
        output IOCS,
        output RefReq,
        output IODone,
        input  Ready,
        input  IOREQ,
        input  RefActive,
        input  RefAck,
        input  IOTimeout
    );

    modport slave (
        input  BACT,
        input  RAMCS,
        input  ROMCS,
        input  IOCS,
        input  RefReq,
        input  IODone,
        output Ready,
        output IOREQ,
        output RefActive,
        output RefAck,
        output IOTimeout
    );
endinterface

// File: rtl/ready_gen.sv
//------------------------------------------------------------------------------
// ready_gen
//
// Purpose : Wait-state and Ready generator for the FSB bus-cycle block.
//           Holds Ready low for the programmed RAM/ROM wait states, for a
//           refresh in progress, or until the I/O bridge reports completion.
//           Refresh requests are latched and the refresh is run only in an
//           IDLE cycle with no bus cycle active, so CPU accesses always win.
//
// Parameters:
//   RAM_WS  - RAM wait states (FCLK periods Ready held low), 0..15
//   ROM_WS  - ROM wait states, 0..15
//   REF_CYC - refresh duration in FCLK periods, 1..15
//   IO_TO   - I/O timeout in FCLK periods, 1..255 (IO_TIMEOUT_EN only)
//
// Ports:
//   FCLK - sole clock, all logic on the rising edge
//   nRES - synchronous active-low reset
//   bus  - ready_gen_if.slave: BACT/RAMCS/ROMCS/IOCS/RefReq/IODone in,
//          Ready/IOREQ/RefActive/RefAck/IOTimeout out
//
// Build option:
//   IO_TIMEOUT_EN - when defined, an I/O access that sees no IODone for IO_TO
//                   IOW cycles is completed anyway (Ready high) and IOTimeout
//                   pulses. When undefined, IOW waits indefinitely and
//                   IOTimeout is tied low.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ready_gen #(
    parameter int RAM_WS  = 1,
    parameter int ROM_WS  = 2,
    parameter int REF_CYC = 3,
    parameter int IO_TO   = 255
) (
    input  logic        FCLK,
    input  logic        nRES,
    ready_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CNT  = 3'd1,
        REF  = 3'd2,
        IOW  = 3'd3,
        HOLD = 3'd4
    } state_t;

    // Cycle 0 (in IDLE) is already the first low period, and the last low
    // period is the CNT cycle that sees cnt==0, hence the "- 2".
    localparam logic [3:0] RAM_CNT_INIT = (RAM_WS >= 2) ? 4'(RAM_WS - 2) : 4'd0;
    localparam logic [3:0] ROM_CNT_INIT = (ROM_WS >= 2) ? 4'(ROM_WS - 2) : 4'd0;
    localparam logic [3:0] REF_CNT_INIT = 4'(REF_CYC - 1);
    localparam logic       RAM_HAS_WS   = (RAM_WS != 0);
    localparam logic       ROM_HAS_WS   = (ROM_WS != 0);
    localparam logic       RAM_SHORT    = (RAM_WS <= 1);
    localparam logic       ROM_SHORT    = (ROM_WS <= 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       refpend_q, refpend_d;
    logic       ioreq_q, ioreq_d;
    logic       refack_q, refack_d;
    logic       idle_ready;
    logic       ready_dec;

`ifdef IO_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(IO_TO - 1);

    logic [7:0] to_cnt_q, to_cnt_d;
    logic       iotmo_q, iotmo_d;
`endif

    // Ready must be valid in cycle 0 of an access, before any register has
    // seen BACT, so the IDLE value is decoded straight from the selects.
    assign idle_ready = !((bus.RAMCS && RAM_HAS_WS) ||
                          (bus.ROMCS && ROM_HAS_WS) ||
                          bus.IOCS);

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge FCLK) begin
        if (!nRES) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            refpend_q <= 1'b0;
            ioreq_q   <= 1'b0;
            refack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            refpend_q <= refpend_d;
            ioreq_q   <= ioreq_d;
            refack_q  <= refack_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ioreq_d   = ioreq_q;
        refack_d  = 1'b0;
        // Requests arriving while one is already pending merge into it.
        refpend_d = refpend_q | bus.RefReq;
`ifdef IO_TIMEOUT_EN
        iotmo_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // Any active bus cycle beats a pending refresh.
                if (bus.BACT && bus.IOCS) begin
                    state_d = IOW;
                    ioreq_d = 1'b1;
                end else if (bus.BACT && bus.RAMCS) begin
                    if (RAM_SHORT) begin
                        state_d = HOLD;
                    end else begin
                        state_d = CNT;
                        cnt_d   = RAM_CNT_INIT;
                    end
                end else if (bus.BACT && bus.ROMCS) begin
                    if (ROM_SHORT) begin
                        state_d = HOLD;
                    end else begin
                        state_d = CNT;
                        cnt_d   = ROM_CNT_INIT;
                    end
                end else if (bus.BACT) begin
                    state_d = HOLD;
                end else if (refpend_q) begin
                    state_d   = REF;
                    cnt_d     = REF_CNT_INIT;
                    // Entering REF consumes the pending request; a request
                    // on this very edge starts a new one.
                    refpend_d = bus.RefReq;
                end
            end

            CNT: begin
                if (!bus.BACT) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            REF: begin
                // BACT is ignored here; IDLE picks the access up afterwards
                // because it is level-sensitive.
                if (cnt_q == 4'd0) begin
                    state_d  = IDLE;
                    refack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            IOW: begin
                if (!bus.BACT) begin
                    state_d = IDLE;
                    ioreq_d = 1'b0;
                end else if (bus.IODone) begin
                    state_d = HOLD;
                    ioreq_d = 1'b0;
                end
`ifdef IO_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = HOLD;
                    ioreq_d = 1'b0;
                    iotmo_d = 1'b1;
                end
`endif
            end

            HOLD: begin
                if (!bus.BACT) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                ioreq_d = 1'b0;
            end
        endcase
    end

`ifdef IO_TIMEOUT_EN
    //--------------------------------------------------------------------------
    // I/O timeout counter: zero outside IOW, so it is cleared on IOW entry and
    // counts the IOW cycles seen so far.
    //--------------------------------------------------------------------------
    always_comb begin
        to_cnt_d = 8'd0;
        if (state_q == IOW) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge FCLK) begin
        if (!nRES) begin
            to_cnt_q <= 8'd0;
            iotmo_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            iotmo_q  <= iotmo_d;
        end
    end

    assign bus.IOTimeout = iotmo_q;
`else
    logic unused_io_to;

    assign unused_io_to  = (IO_TO != 0);
    assign bus.IOTimeout = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Output decode
    //--------------------------------------------------------------------------
    always_comb begin
        ready_dec = 1'b0;
        case (state_q)
            IDLE:    ready_dec = idle_ready;
            HOLD:    ready_dec = 1'b1;
            default: ready_dec = 1'b0;
        endcase
    end

    assign bus.Ready     = ready_dec;
    assign bus.IOREQ     = ioreq_q;
    assign bus.RefActive = (state_q == REF);
    assign bus.RefAck    = refack_q;

endmodule

// File: tb/tb_ready_gen.sv
`timescale 1ns/1ps

module tb_ready_gen;

    localparam int RAM_WS  = 1;
    localparam int ROM_WS  = 2;
    localparam int REF_CYC = 3;
    localparam int IO_TO   = 4;
    localparam int N_RAND  = 2000;

    logic FCLK = 1'b0;
    logic nRES = 1'b0;

    ready_gen_if bus ();

    ready_gen #(
        .RAM_WS  (RAM_WS),
        .ROM_WS  (ROM_WS),
        .REF_CYC (REF_CYC),
        .IO_TO   (IO_TO)
    ) dut (
        .FCLK (FCLK),
        .nRES (nRES),
        .bus  (bus)
    );

    always #5 FCLK = ~FCLK;

    // in  = {nRES, BACT, RAMCS, ROMCS, IOCS, RefReq, IODone}
    // exp = {Ready, IOREQ, RefActive, RefAck, IOTimeout}
    typedef struct {
        logic [6:0] in;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: an access is either waiting (some low periods still
    // owed, or an I/O completion still owed) or ready; a refresh is a count
    // of remaining RefActive periods.
    int   m_ref_left = 0;
    int   m_low_left = 0;
    int   m_io_cyc   = 0;
    bit   m_pend     = 0;
    bit   m_acc      = 0;
    bit   m_io_wait  = 0;
    bit   m_ack      = 0;
    bit   m_tmo      = 0;

    function automatic void add(input logic [6:0] in, input logic [4:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    task automatic drive(input logic [6:0] in);
        {nRES, bus.BACT, bus.RAMCS, bus.ROMCS, bus.IOCS, bus.RefReq, bus.IODone} = in;
    endtask

    function automatic logic [4:0] outs();
        return {bus.Ready, bus.IOREQ, bus.RefActive, bus.RefAck, bus.IOTimeout};
    endfunction

    task automatic check(input string name, input int idx, input logic [4:0] got,
                         input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: Ready/IOREQ/RefActive/RefAck/IOTimeout got %b, expected %b",
                     name, idx, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One FCLK period: apply inputs after the edge, compare mid-period.
    task automatic step(input logic [6:0] in, input logic [4:0] exp,
                        input string name, input int idx);
        drive(in);
        #1;
        check(name, idx, outs(), exp);
        @(posedge FCLK);
        #1;
    endtask

    function automatic logic [4:0] model_out(input logic [6:0] in);
        logic ram, rom, io, rdy;
        ram = in[4];
        rom = in[3];
        io  = in[2];
        if (m_ref_left > 0)
            rdy = 1'b0;
        else if (m_acc)
            rdy = !m_io_wait && (m_low_left == 0);
        else
            rdy = !((ram && RAM_WS != 0) || (rom && ROM_WS != 0) || io);
        return {rdy, m_acc && m_io_wait, m_ref_left > 0, m_ack, m_tmo};
    endfunction

    task automatic model_edge(input logic [6:0] in);
        logic nres, b, ram, rom, io, rq, dn;
        bit   n_pend, n_ack, n_tmo;
        {nres, b, ram, rom, io, rq, dn} = in;
        if (!nres) begin
            m_ref_left = 0; m_low_left = 0; m_io_cyc = 0;
            m_pend = 0; m_acc = 0; m_io_wait = 0; m_ack = 0; m_tmo = 0;
            return;
        end
        n_pend = m_pend || rq;
        n_ack  = (m_ref_left == 1);
        n_tmo  = 0;
        if (m_ref_left > 0) begin
            m_ref_left--;
        end else if (m_acc) begin
            if (!b) begin
                m_acc = 0; m_io_wait = 0; m_low_left = 0;
            end else if (m_io_wait) begin
                if (dn) begin
                    m_io_wait = 0;
                end else begin
`ifdef IO_TIMEOUT_EN
                    m_io_cyc++;
                    if (m_io_cyc == IO_TO) begin
                        m_io_wait = 0;
                        n_tmo     = 1;
                    end
`endif
                end
            end else if (m_low_left > 0) begin
                m_low_left--;
            end
        end else begin
            if (b) begin
                m_acc     = 1;
                m_io_wait = io;
                m_io_cyc  = 0;
                if (io)       m_low_left = 0;
                else if (ram) m_low_left = (RAM_WS > 0) ? RAM_WS - 1 : 0;
                else if (rom) m_low_left = (ROM_WS > 0) ? ROM_WS - 1 : 0;
                else          m_low_left = 0;
            end else if (m_pend) begin
                m_ref_left = REF_CYC;
                n_pend     = rq;
            end
        end
        m_pend = n_pend;
        m_ack  = n_ack;
        m_tmo  = n_tmo;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] in;
        logic [4:0] exp;
        int         tx_left;
        int         tx_sel;
        int         low_cnt;
        int         req_cnt;

        // Reset and idle
        add(7'b0000000, 5'b10000);
        add(7'b1000000, 5'b10000);
        // RAM, 1 wait state
        add(7'b1110000, 5'b00000);
        add(7'b1110000, 5'b10000);
        add(7'b1110000, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1010000, 5'b00000);
        // ROM, 2 wait states
        add(7'b1101000, 5'b00000);
        add(7'b1101000, 5'b00000);
        add(7'b1101000, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b10000);
        // No select
        add(7'b1100000, 5'b10000);
        add(7'b1100000, 5'b10000);
        add(7'b1000000, 5'b10000);
        // Refresh while idle
        add(7'b1000010, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b10010);
        add(7'b1000000, 5'b10000);
        // RAM access arriving in 2nd refresh period
        add(7'b1000010, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b00100);
        add(7'b1110000, 5'b00100);
        add(7'b1110000, 5'b00100);
        add(7'b1110000, 5'b00010);
        add(7'b1110000, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b10000);
        // I/O completing after 3 cycles
        add(7'b1100100, 5'b00000);
        add(7'b1100100, 5'b01000);
        add(7'b1100100, 5'b01000);
        add(7'b1100101, 5'b01000);
        add(7'b1100100, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b10000);
        // I/O abort
        add(7'b1100100, 5'b00000);
        add(7'b1100100, 5'b01000);
        add(7'b1000000, 5'b01000);
        add(7'b1000100, 5'b00000);
        add(7'b1000000, 5'b10000);
        // ROM abort in CNT
        add(7'b1101000, 5'b00000);
        add(7'b1000000, 5'b00000);
        add(7'b1001000, 5'b00000);
        add(7'b1000000, 5'b10000);
        // Reset during CNT
        add(7'b1101000, 5'b00000);
        add(7'b0101000, 5'b00000);
        add(7'b1001000, 5'b00000);
        add(7'b1000000, 5'b10000);
        // Reset during REF (RefReq at the reset edge is dropped)
        add(7'b1000010, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b00100);
        add(7'b0000010, 5'b00100);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b10000);
        // RefReq coincident with RAM access
        add(7'b1110010, 5'b00000);
        add(7'b1110000, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b10000);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b10010);
        // RefReq on the REF entry edge queues a second refresh
        add(7'b1000010, 5'b10000);
        add(7'b1000010, 5'b10000);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b10010);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b00100);
        add(7'b1000000, 5'b10010);
        add(7'b1000000, 5'b10000);

        drive(7'b0000000);
        repeat (2) @(posedge FCLK);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].exp, "table", i);
        end

`ifdef IO_TIMEOUT_EN
        // I/O with no IODone: completes after IO_TO IOW cycles
        step(7'b1100100, 5'b00000, "io_tmo", 0);
        for (int i = 1; i <= IO_TO; i++) begin
            step(7'b1100100, 5'b01000, "io_tmo", i);
        end
        step(7'b1100100, 5'b10001, "io_tmo", IO_TO + 1);
        step(7'b1100100, 5'b10000, "io_tmo", IO_TO + 2);
        step(7'b1000000, 5'b10000, "io_tmo", IO_TO + 3);
        step(7'b1000000, 5'b10000, "io_tmo", IO_TO + 4);
`else
        // I/O with IODone during cycle 5
        step(7'b1100100, 5'b00000, "io5", 0);
        for (int i = 1; i <= 5; i++) begin
            in = (i == 5) ? 7'b1100101 : 7'b1100100;
            step(in, 5'b01000, "io5", i);
        end
        step(7'b1100100, 5'b10000, "io5", 6);
        step(7'b1000000, 5'b10000, "io5", 7);
        step(7'b1000000, 5'b10000, "io5", 8);

        // I/O with no IODone waits indefinitely
        step(7'b1100100, 5'b00000, "io_wait", 0);
        low_cnt = 0;
        req_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            drive(7'b1100100);
            #1;
            if (bus.Ready === 1'b0) low_cnt++;
            if (bus.IOREQ === 1'b1 && bus.IOTimeout === 1'b0) req_cnt++;
            @(posedge FCLK);
            #1;
        end
        check_int("io_wait_ready_low", low_cnt, 300);
        check_int("io_wait_ioreq_high", req_cnt, 300);
        step(7'b1000000, 5'b01000, "io_wait", 1);
        step(7'b1000000, 5'b10000, "io_wait", 2);
`endif

        // Randomized traffic against the reference model
        tx_left = 0;
        tx_sel  = 0;
        for (int i = 0; i < N_RAND; i++) begin
            logic b;
            if (tx_left > 0) begin
                b = 1'b1;
                tx_left--;
            end else begin
                b = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    tx_sel  = int'($urandom_range(0, 3));
                    tx_left = int'($urandom_range(1, 12));
                end
            end
            in[6] = (i == 0) ? 1'b0 : ($urandom_range(0, 249) != 0);
            in[5] = b;
            in[4] = b && (tx_sel == 1);
            in[3] = b && (tx_sel == 2);
            in[2] = b && (tx_sel == 3);
            in[1] = ($urandom_range(0, 11) == 0);
            in[0] = ($urandom_range(0, 5) == 0);
            drive(in);
            #1;
            exp = model_out(in);
            check("random", i, outs(), exp);
            model_edge(in);
            @(posedge FCLK);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
